// File: rtl/puf_pkg.sv
// Shared types and helpers for the arbiter-PUF challenge sequencer.
// Define PUF_LFSR_EN to step challenges as a Fibonacci LFSR; otherwise they count up.
package puf_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        CAPTURE = 3'd2,
        NEXT    = 3'd3,
        OUTPUT  = 3'd4
    } state_t;

    localparam int         C_LENGTH_DEF  = 8;
    localparam logic [7:0] LFSR_TAPS_DEF = 8'hB8;

    // Challenges are handled zero-extended to a fixed width so one helper serves any C_LENGTH.
    localparam int CHAL_MAX = 32;
    typedef logic [CHAL_MAX-1:0] chal_ext_t;

    function automatic chal_ext_t next_challenge(
        input chal_ext_t chal,
        input chal_ext_t taps,
        input chal_ext_t mask
    );
        chal_ext_t result;
`ifdef PUF_LFSR_EN
        result = ((chal << 1) | chal_ext_t'(^(chal & taps & mask))) & mask;
`else
        result = (chal + chal_ext_t'(1)) & mask & (taps | ~taps);
`endif
        return result;
    endfunction

endpackage

// File: rtl/puf_resp_sync.sv
// Two-flop synchronizer for the asynchronous arbiter response.
// Synchronous active-low reset; both stages hold while ena is low.
module puf_resp_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic async_in,
    output logic sync_out
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else if (ena) begin
            meta_reg <= async_in;
            sync_reg <= meta_reg;
        end
    end

    assign sync_out = sync_reg;

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Arbiter-PUF controller: settle, launch and capture VOTES times per challenge, majority-vote each
// challenge, and hand N_RESP voted bits to the host. PUF_LFSR_EN selects LFSR challenge stepping.
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int                  C_LENGTH    = C_LENGTH_DEF,
    parameter int                  N_RESP      = 8,
    parameter int                  VOTES       = 5,
    parameter int                  SETTLE_CYC  = 4,
    parameter int                  CAPTURE_CYC = 4,
    parameter logic [C_LENGTH-1:0] LFSR_TAPS   = C_LENGTH'(LFSR_TAPS_DEF)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic                start,
    input  logic [C_LENGTH-1:0] seed,
    output logic                busy,
    output logic [C_LENGTH-1:0] puf_challenge,
    output logic                puf_pulse,
    input  logic                puf_response,
    output logic [N_RESP-1:0]   resp_data,
    output logic                resp_valid,
    input  logic                resp_ready
);

    localparam int CNT_W  = $clog2(VOTES + 1);
    localparam int BIT_W  = (N_RESP > 1) ? $clog2(N_RESP) : 1;
    localparam int PH_MAX = (SETTLE_CYC > CAPTURE_CYC) ? SETTLE_CYC : CAPTURE_CYC;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    generate
        if (VOTES < 1 || (VOTES % 2) == 0) begin : g_bad_votes
            $error("VOTES must be odd and at least 1");
        end
        if (SETTLE_CYC < 1) begin : g_bad_settle
            $error("SETTLE_CYC must be at least 1");
        end
        if (CAPTURE_CYC < 3) begin : g_bad_capture
            $error("CAPTURE_CYC must be at least 3 to cover the response synchronizer");
        end
        if (C_LENGTH < 1 || C_LENGTH > CHAL_MAX) begin : g_bad_length
            $error("C_LENGTH out of supported range");
        end
    endgenerate

    state_t              state_reg;
    state_t              state_next;
    logic [PH_W-1:0]     phase_reg;
    logic [CNT_W-1:0]    ones_reg;
    logic [CNT_W-1:0]    eval_reg;
    logic [BIT_W-1:0]    bit_reg;
    logic [C_LENGTH-1:0] chal_reg;
    logic [N_RESP-1:0]   data_reg;
    logic [N_RESP-1:0]   bit_sel;

    logic                resp_sync;
    logic                settle_done;
    logic                capture_done;
    logic                last_eval;
    logic                last_bit;
    logic                vote;

    logic [C_LENGTH-1:0] chal_load;
    logic [C_LENGTH-1:0] chal_adv;
    chal_ext_t           chal_ext;
    chal_ext_t           taps_ext;
    chal_ext_t           mask_ext;
    chal_ext_t           adv_ext;
    logic                unused_adv;

    puf_resp_sync u_resp_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .async_in (puf_response),
        .sync_out (resp_sync)
    );

    assign settle_done  = (state_reg == SETTLE)  && (phase_reg == PH_W'(SETTLE_CYC - 1));
    assign capture_done = (state_reg == CAPTURE) && (phase_reg == PH_W'(CAPTURE_CYC - 1));
    assign last_eval    = (eval_reg == CNT_W'(VOTES - 1));
    assign last_bit     = (bit_reg == BIT_W'(N_RESP - 1));
    assign vote         = (ones_reg > CNT_W'(VOTES / 2));

`ifdef PUF_LFSR_EN
    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    assign chal_load = (seed == '0) ? C_LENGTH'(1) : seed;
`else
    assign chal_load = seed;
`endif

    always_comb begin
        chal_ext = '0;
        taps_ext = '0;
        mask_ext = '0;
        chal_ext[C_LENGTH-1:0] = chal_reg;
        taps_ext[C_LENGTH-1:0] = LFSR_TAPS;
        mask_ext[C_LENGTH-1:0] = '1;
        adv_ext  = next_challenge(chal_ext, taps_ext, mask_ext);
        chal_adv = adv_ext[C_LENGTH-1:0];
    end

    assign unused_adv = ^adv_ext;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else if (ena) begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_done) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                if (capture_done) begin
                    state_next = last_eval ? NEXT : SETTLE;
                end
            end
            NEXT: begin
                state_next = last_bit ? OUTPUT : SETTLE;
            end
            OUTPUT: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decode the registered state only, so ena=0 freezes them along with the FSM.
    always_comb begin
        busy       = 1'b0;
        puf_pulse  = 1'b0;
        resp_valid = 1'b0;
        case (state_reg)
            SETTLE, NEXT: begin
                busy = 1'b1;
            end
            CAPTURE: begin
                busy      = 1'b1;
                puf_pulse = 1'b1;
            end
            OUTPUT: begin
                busy       = 1'b1;
                resp_valid = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // The challenge moves only on IDLE->SETTLE and in NEXT, both while the pulse is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_reg <= '0;
            ones_reg  <= '0;
            eval_reg  <= '0;
            bit_reg   <= '0;
            chal_reg  <= '0;
        end else if (ena) begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        chal_reg  <= chal_load;
                        phase_reg <= '0;
                        ones_reg  <= '0;
                        eval_reg  <= '0;
                        bit_reg   <= '0;
                    end
                end
                SETTLE: begin
                    phase_reg <= settle_done ? '0 : phase_reg + PH_W'(1);
                end
                CAPTURE: begin
                    phase_reg <= capture_done ? '0 : phase_reg + PH_W'(1);
                    if (capture_done) begin
                        ones_reg <= ones_reg + CNT_W'(resp_sync);
                        eval_reg <= eval_reg + CNT_W'(1);
                    end
                end
                NEXT: begin
                    chal_reg <= chal_adv;
                    ones_reg <= '0;
                    eval_reg <= '0;
                    if (!last_bit) begin
                        bit_reg <= bit_reg + BIT_W'(1);
                    end
                end
                default: begin
                    phase_reg <= phase_reg;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < N_RESP; gi++) begin : g_bit_sel
        assign bit_sel[gi] = (bit_reg == BIT_W'(gi));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_reg <= '0;
        end else if (ena && state_reg == NEXT) begin
            data_reg <= (data_reg & ~bit_sel) | ({N_RESP{vote}} & bit_sel);
        end
    end

    assign puf_challenge = chal_reg;
    assign resp_data     = data_reg;

endmodule
